// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: pipeline control, ID-side instruction fields,
// MEM/WB forwarding sources and the EX-side outputs toward the ALU.
interface id_ex_operand_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
);
  // Pipeline control from the hazard controller
  logic               stall;
  logic               flush;
  // Decoded instruction in ID
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic [4:0]         id_rs1_addr;
  logic [4:0]         id_rs2_addr;
  logic [4:0]         id_rd_addr;
  logic [ALUOP_W-1:0] id_aluop;
  logic               id_sel_a;
  logic               id_sel_b;
  logic               id_reg_wr;
  logic               id_mem_rd;
  logic               id_mem_wr;
  // Forwarding sources
  logic               mem_reg_wr;
  logic [4:0]         mem_rd_addr;
  logic [XLEN-1:0]    mem_fwd_data;
  logic               wb_reg_wr;
  logic [4:0]         wb_rd_addr;
  logic [XLEN-1:0]    wb_wdata;
  // EX-side outputs
  logic               ex_valid;
  logic [XLEN-1:0]    opr_a;
  logic [XLEN-1:0]    opr_b;
  logic [ALUOP_W-1:0] aluop;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_store_data;
  logic [4:0]         ex_rd_addr;
  logic               ex_reg_wr;
  logic               ex_mem_rd;
  logic               ex_mem_wr;
  logic               load_use_hazard;

  modport master (
    output stall, flush,
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1_addr, id_rs2_addr, id_rd_addr, id_aluop,
    output id_sel_a, id_sel_b, id_reg_wr, id_mem_rd, id_mem_wr,
    output mem_reg_wr, mem_rd_addr, mem_fwd_data,
    output wb_reg_wr, wb_rd_addr, wb_wdata,
    input  ex_valid, opr_a, opr_b, aluop, ex_pc, ex_store_data,
    input  ex_rd_addr, ex_reg_wr, ex_mem_rd, ex_mem_wr, load_use_hazard
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1_addr, id_rs2_addr, id_rd_addr, id_aluop,
    input  id_sel_a, id_sel_b, id_reg_wr, id_mem_rd, id_mem_wr,
    input  mem_reg_wr, mem_rd_addr, mem_fwd_data,
    input  wb_reg_wr, wb_rd_addr, wb_wdata,
    output ex_valid, opr_a, opr_b, aluop, ex_pc, ex_store_data,
    output ex_rd_addr, ex_reg_wr, ex_mem_rd, ex_mem_wr, load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded fields, forwards
// MEM/WB results into the registered operands and flags load-use hazards.
module id_ex_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input logic                   i_clk,
  input logic                   i_rst,
  id_ex_operand_stage_if.slave  bus
);

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_rs1;
  logic [XLEN-1:0]    r_rs2;
  logic [XLEN-1:0]    r_imm;
  logic [4:0]         r_rs1_addr;
  logic [4:0]         r_rs2_addr;
  logic [4:0]         r_rd_addr;
  logic [ALUOP_W-1:0] r_aluop;
  logic               r_sel_a;
  logic               r_sel_b;
  logic               r_reg_wr;
  logic               r_mem_rd;
  logic               r_mem_wr;

  logic [XLEN-1:0]    w_fwd_rs1;
  logic [XLEN-1:0]    w_fwd_rs2;

  // Pipeline register update: reset/flush insert a bubble, stall holds control
  // but refreshes rs1/rs2 so a producer leaving WB mid-stall is not lost.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.flush) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_aluop    <= '0;
      r_sel_a    <= 1'b0;
      r_sel_b    <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
    end else if (bus.stall) begin
      r_rs1 <= w_fwd_rs1;
      r_rs2 <= w_fwd_rs2;
    end else begin
      r_valid    <= bus.id_valid;
      r_pc       <= bus.id_pc;
      r_rs1      <= bus.id_rs1_data;
      r_rs2      <= bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_rs1_addr <= bus.id_rs1_addr;
      r_rs2_addr <= bus.id_rs2_addr;
      r_rd_addr  <= bus.id_rd_addr;
      r_aluop    <= bus.id_aluop;
      r_sel_a    <= bus.id_sel_a;
      r_sel_b    <= bus.id_sel_b;
      // An invalid slot must never write state downstream
      r_reg_wr   <= bus.id_valid & bus.id_reg_wr;
      r_mem_rd   <= bus.id_valid & bus.id_mem_rd;
      r_mem_wr   <= bus.id_valid & bus.id_mem_wr;
    end
  end

  // rs1 forwarding: x0 never forwarded, MEM is younger so it beats WB
  always_comb begin
    w_fwd_rs1 = r_rs1;
    if (r_rs1_addr != 5'd0) begin
      if (bus.mem_reg_wr && (bus.mem_rd_addr == r_rs1_addr)) begin
        w_fwd_rs1 = bus.mem_fwd_data;
      end else if (bus.wb_reg_wr && (bus.wb_rd_addr == r_rs1_addr)) begin
        w_fwd_rs1 = bus.wb_wdata;
      end
    end
  end

  // rs2 forwarding, same priority as rs1
  always_comb begin
    w_fwd_rs2 = r_rs2;
    if (r_rs2_addr != 5'd0) begin
      if (bus.mem_reg_wr && (bus.mem_rd_addr == r_rs2_addr)) begin
        w_fwd_rs2 = bus.mem_fwd_data;
      end else if (bus.wb_reg_wr && (bus.wb_rd_addr == r_rs2_addr)) begin
        w_fwd_rs2 = bus.wb_wdata;
      end
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.opr_a         = r_sel_a ? r_pc : w_fwd_rs1;
  assign bus.opr_b         = r_sel_b ? r_imm : w_fwd_rs2;
  assign bus.aluop         = r_aluop;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_store_data = w_fwd_rs2;
  assign bus.ex_rd_addr    = r_rd_addr;
  assign bus.ex_reg_wr     = r_reg_wr;
  assign bus.ex_mem_rd     = r_mem_rd;
  assign bus.ex_mem_wr     = r_mem_wr;

  // Conservative: rs2 is compared even for instructions that ignore it
  assign bus.load_use_hazard = r_valid & r_mem_rd & (r_rd_addr != 5'd0) & bus.id_valid &
                               ((bus.id_rs1_addr == r_rd_addr) |
                                (bus.id_rs2_addr == r_rd_addr));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: the driver pushes the expected EX
// outputs for each cycle into a queue; a negedge monitor pops and compares.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .ALUOP_W(4)) bus ();

  id_ex_operand_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        hz;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, fld, act, exp);
    end
  endtask

  // Monitor: compares every output once per cycle for which an expectation exists
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "ex_valid", 32'(bus.ex_valid), 32'(e.v));
      chk(e.name, "opr_a", bus.opr_a, e.a);
      chk(e.name, "opr_b", bus.opr_b, e.b);
      chk(e.name, "aluop", 32'(bus.aluop), 32'(e.op));
      chk(e.name, "ex_pc", bus.ex_pc, e.pc);
      chk(e.name, "ex_store_data", bus.ex_store_data, e.st);
      chk(e.name, "ex_rd_addr", 32'(bus.ex_rd_addr), 32'(e.rd));
      chk(e.name, "ex_reg_wr", 32'(bus.ex_reg_wr), 32'(e.rw));
      chk(e.name, "ex_mem_rd", 32'(bus.ex_mem_rd), 32'(e.mr));
      chk(e.name, "ex_mem_wr", 32'(bus.ex_mem_wr), 32'(e.mw));
      chk(e.name, "load_use_hazard", 32'(bus.load_use_hazard), 32'(e.hz));
    end
  end

  task automatic push(input string name, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] op, input logic [31:0] pc,
                      input logic [31:0] st, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic mw, input logic hz);
    exp_t e;
    e.name = name; e.v = v; e.a = a; e.b = b; e.op = op; e.pc = pc; e.st = st;
    e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.hz = hz;
    q.push_back(e);
  endtask

  task automatic push_zero(input string name);
    push(name, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1a,
                        input logic [31:0] rs1d, input logic [4:0] rs2a,
                        input logic [31:0] rs2d, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [3:0] op, input logic sa,
                        input logic sb, input logic rw, input logic mr, input logic mw);
    bus.id_valid = v;      bus.id_pc = pc;
    bus.id_rs1_addr = rs1a; bus.id_rs1_data = rs1d;
    bus.id_rs2_addr = rs2a; bus.id_rs2_data = rs2d;
    bus.id_imm = imm;      bus.id_rd_addr = rd;  bus.id_aluop = op;
    bus.id_sel_a = sa;     bus.id_sel_b = sb;
    bus.id_reg_wr = rw;    bus.id_mem_rd = mr;   bus.id_mem_wr = mw;
  endtask

  task automatic set_mem(input logic w, input logic [4:0] rd, input logic [31:0] d);
    bus.mem_reg_wr = w; bus.mem_rd_addr = rd; bus.mem_fwd_data = d;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_reg_wr = w; bus.wb_rd_addr = rd; bus.wb_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with busy, nonzero inputs everywhere
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1'b1, 32'h44, 5'd1, 32'hdead, 5'd2, 32'hbeef, 32'h12, 5'd5, 4'hf,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    set_mem(1'b1, 5'd1, 32'h111);
    set_wb(1'b1, 5'd2, 32'h222);
    step();
    push_zero("reset_c1");
    step();
    push_zero("reset_c2");
    rst = 1'b0;
    set_mem(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    // ADD x3 = x1 + x2
    set_id(1'b1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 4'h0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    step();
    push("add", 1'b1, 32'd5, 32'd7, 4'h0, 32'h40, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    set_id(1'b1, 32'h44, 5'd3, 32'h77, 5'd6, 32'h5, 32'h0, 5'd7, 4'h2,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // MEM and WB both match rs1: MEM wins
    step();
    set_mem(1'b1, 5'd3, 32'h10);
    set_wb(1'b1, 5'd3, 32'h20);
    push("fwd_mem_prio", 1'b1, 32'h10, 32'h5, 4'h2, 32'h44, 32'h5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // Only WB matches
    step();
    set_mem(1'b0, 5'd3, 32'h10);
    push("fwd_wb", 1'b1, 32'h20, 32'h5, 4'h2, 32'h44, 32'h5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    set_id(1'b1, 32'h48, 5'd0, 32'h33, 5'd6, 32'h5, 32'h0, 5'd7, 4'h2,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // rs1 = x0 is never forwarded even when producers claim x0
    step();
    set_mem(1'b1, 5'd0, 32'h10);
    set_wb(1'b1, 5'd0, 32'h20);
    push("fwd_x0", 1'b1, 32'h33, 32'h5, 4'h2, 32'h48, 32'h5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // LW x5, 8(x1)
    set_id(1'b1, 32'h4c, 5'd1, 32'h1000, 5'd0, 32'h0, 32'd8, 5'd5, 4'h0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // LW in EX, ID reads x5 through rs2: hazard, controller flushes
    step();
    set_mem(1'b0, 5'd0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h50, 5'd9, 32'h9, 5'd5, 32'h55, 32'h0, 5'd8, 4'h1,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    push("lw_hazard", 1'b1, 32'h1000, 32'd8, 4'h0, 32'h4c, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);

    step();
    bus.flush = 1'b0;
    push_zero("flush_bubble");

    step();
    push("dep_after_bubble", 1'b1, 32'h9, 32'h55, 4'h1, 32'h50, 32'h55, 5'd8,
         1'b1, 1'b0, 1'b0, 1'b0);
    set_id(1'b1, 32'h54, 5'd1, 32'h11, 5'd4, 32'h0, 32'h0, 5'd10, 4'h3,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stall 3 cycles; WB writes x4 in the first only
    step();
    bus.stall = 1'b1;
    set_wb(1'b1, 5'd4, 32'h99);
    set_id(1'b1, 32'h60, 5'd2, 32'h22, 5'd3, 32'h1234, 32'h0, 5'd11, 4'h7,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("stall_c1", 1'b1, 32'h11, 32'h99, 4'h3, 32'h54, 32'h99, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    step();
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h64, 5'd2, 32'h22, 5'd3, 32'h4321, 32'h0, 5'd11, 4'h7,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("stall_c2", 1'b1, 32'h11, 32'h99, 4'h3, 32'h54, 32'h99, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    step();
    push("stall_c3", 1'b1, 32'h11, 32'h99, 4'h3, 32'h54, 32'h99, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    step();
    bus.stall = 1'b0;
    set_id(1'b1, 32'h68, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd12, 4'h4,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("stall_release", 1'b1, 32'h11, 32'h99, 4'h3, 32'h54, 32'h99, 5'd10,
         1'b1, 1'b0, 1'b0, 1'b0);

    // Flush together with stall: flush wins
    step();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    push("after_release", 1'b1, 32'h1, 32'h2, 4'h4, 32'h68, 32'h2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);

    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    push_zero("flush_over_stall");
    set_id(1'b1, 32'h100, 5'd2, 32'hab, 5'd6, 32'h66, 32'hffff_fffc, 5'd13, 4'h5,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // PC / immediate operands; store data still carries forwarded rs2
    step();
    set_wb(1'b1, 5'd6, 32'h77);
    push("pc_imm_sel", 1'b1, 32'h100, 32'hffff_fffc, 4'h5, 32'h100, 32'h77, 5'd13,
         1'b1, 1'b0, 1'b0, 1'b0);
    set_id(1'b0, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd14, 4'h6,
           1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Invalid ID slot captured: side-effect controls forced low
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    bus.stall = 1'b1;
    set_id(1'b1, 32'h108, 5'd1, 32'h5, 5'd2, 32'h6, 32'h7, 5'd15, 4'h8,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push("invalid_capture", 1'b0, 32'h0, 32'h0, 4'h6, 32'h104, 32'h0, 5'd14,
         1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during stall discards the held instruction
    step();
    rst = 1'b0;
    bus.stall = 1'b0;
    push_zero("reset_mid_stall");
    set_id(1'b1, 32'h200, 5'd3, 32'h30, 5'd0, 32'h0, 32'd4, 5'd0, 4'h0,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Load to x0 never raises a hazard, even when ID reads x0
    step();
    set_id(1'b1, 32'h204, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, 4'h0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("lw_x0_no_hazard", 1'b1, 32'h30, 32'd4, 4'h0, 32'h200, 32'h0, 5'd0,
         1'b1, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded instruction fields on each clock and resolves data hazards by forwarding from the MEM and WB stages.
- Drives the ALU's opr_a, opr_b and aluop.
- Flags load-use hazards so the hazard controller can stall IF/ID and flush this stage.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold current EX contents
flush  in  1  replace EX contents with a bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register-file rs1 value
id_rs2_data  in  XLEN  register-file rs2 value
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr  in  5  rs1 index
id_rs2_addr  in  5  rs2 index
id_rd_addr  in  5  rd index
id_aluop  in  ALUOP_W  ALU operation code
id_sel_a  in  1  0: rs1, 1: PC
id_sel_b  in  1  0: rs2, 1: immediate
id_reg_wr  in  1  writes rd
id_mem_rd  in  1  is a load
id_mem_wr  in  1  is a store
mem_reg_wr  in  1  MEM-stage instruction writes rd
mem_rd_addr  in  5  MEM-stage rd
mem_fwd_data  in  XLEN  MEM-stage result
wb_reg_wr  in  1  WB-stage instruction writes rd
wb_rd_addr  in  5  WB-stage rd
wb_wdata  in  XLEN  WB write data
ex_valid  out  1  EX holds a real instruction
opr_a  out  XLEN  ALU operand A
opr_b  out  XLEN  ALU operand B
aluop  out  ALUOP_W  ALU operation code
ex_pc  out  XLEN  PC of EX instruction
ex_store_data  out  XLEN  forwarded rs2, for stores
ex_rd_addr  out  5  rd of EX instruction
ex_reg_wr  out  1  EX writes rd (0 in a bubble)
ex_mem_rd  out  1  EX is a load (0 in a bubble)
ex_mem_wr  out  1  EX is a store (0 in a bubble)
load_use_hazard  out  1  ID depends on a load currently in EX

Behaviour:
- Update priority at the clock edge: rst > flush > stall > load.
- rst:
  - All registers go to 0: ex_valid=0, aluop=4'b0000, ex_pc=0, ex_rd_addr=0, ex_reg_wr/ex_mem_rd/ex_mem_wr=0, rs1/rs2/imm registers=0.
  - Consequently opr_a=0, opr_b=0, ex_store_data=0, load_use_hazard=0.
  - Reset mid-stall or mid-hazard discards the held instruction.
- flush (wins over a simultaneous stall): insert a bubble, i.e. the reset values above.
- stall:
  - All control fields are held.
  - rs1/rs2 registers reload with their forwarded values (fwd_rs1/fwd_rs2), so a producer retiring from WB during the stall is not lost.
- load: every ID field is captured into the EX registers.
  - A captured id_valid=0 also forces reg_wr/mem_rd/mem_wr to 0.
- Forwarding is combinational from the registered state. For fwd_rs1 (fwd_rs2 is identical):
  - ex rs1 addr == 0: register value, never forwarded.
  - else if mem_reg_wr and mem_rd_addr match: mem_fwd_data. MEM has priority over WB.
  - else if wb_reg_wr and wb_rd_addr match: wb_wdata.
  - else: registered value.
- Operand selection:
  - opr_a = ex_sel_a ? ex_pc : fwd_rs1.
  - opr_b = ex_sel_b ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2, regardless of sel_b.
- aluop is the registered id_aluop. Latency ID to ALU operands is 1 cycle.
- load_use_hazard is combinational: ex_valid & ex_mem_rd & ex_rd_addr!=0 & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr).
  - Conservative: compared even when the ID instruction does not use rs2.
  - This block does not self-stall. The controller responds by stalling IF/ID and asserting flush here for one cycle.

Test Plan:
1. rst held 2 cycles with id_valid=1 and nonzero inputs → all outputs 0, aluop=0000, load_use_hazard=0.
2. Load ADD (rs1=x1=5, rs2=x2=7, rd=x3, sel_a=0, sel_b=0, aluop=0000) → next cycle opr_a=5, opr_b=7, aluop=0000, ex_rd_addr=3, ex_reg_wr=1.
3. EX rs1=x3 with mem_reg_wr=1, mem_rd=3, mem_fwd_data=0x10, and simultaneously wb_reg_wr=1, wb_rd=3, wb_wdata=0x20 → opr_a=0x10. Drop the MEM match → opr_a=0x20. Set rs1=x0 with mem_rd=0 → opr_a = registered value.
4. EX holds LW rd=x5 (ex_mem_rd=1) and ID has rs2=x5 → load_use_hazard=1. Then flush=1 → next cycle ex_valid=0, ex_reg_wr=0, load_use_hazard=0.
5. stall=1 for 3 cycles while ID changes; WB writes x4=0x99 in cycle 1 only, EX rs2=x4 → aluop/ex_pc unchanged and opr_b=0x99 in all stalled cycles and after release.
6. flush=1 and stall=1 together → bubble inserted. sel_a=1, sel_b=1, pc=0x100, imm=0xFFFFFFFC → opr_a=0x100, opr_b=0xFFFFFFFC, ex_store_data = forwarded rs2.
